// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared state encodings and direction constants for the count sequencer
package count_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LIMIT = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle tick every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    // tick is seen in the last cycle of each period so the consumer can register its strobe on the wrap edge
    assign tick = enable && (count == LAST);

    // count only while enabled; clear wins so a cleared period always restarts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - control FSM turning button pulses and a 1 Hz tick into step/clear strobes
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter bit WRAP       = 1'b1,
    parameter bit AUTO_START = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       dir_pulse,
    input  logic       clear_pulse,
    input  logic       stop_pulse,
    input  logic       at_max,
    input  logic       at_zero,
    output logic       step,
    output logic       dir,
    output logic       clr,
    output logic       running,
    output logic [1:0] state
);

    localparam state_t RESET_STATE = AUTO_START ? S_RUN : S_IDLE;

    state_t cur;
    logic   tick;
    logic   limit_hit;
    logic   presc_clear;

    assign state = cur;

    // limit is judged against the direction currently in force, not one toggled this cycle
    assign limit_hit = ((dir == DIR_UP) && at_max) || ((dir == DIR_DN) && at_zero);

    // idle and limit keep the divider parked at zero so every run starts a full period
    assign presc_clear = clear_pulse || (cur == S_IDLE) || (cur == S_LIMIT);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk   (CLK),
        .rst   (RST),
        .enable(cur == S_RUN),
        .clear (presc_clear),
        .tick  (tick)
    );

    // single-process FSM: strobes default low, clear beats stop and tick, dir toggles regardless
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur     <= RESET_STATE;
            running <= AUTO_START;
            step    <= 1'b0;
            clr     <= 1'b0;
            dir     <= DIR_UP;
        end else begin
            step <= 1'b0;
            clr  <= 1'b0;
            if (dir_pulse) begin
                dir <= ~dir;
            end
            if (clear_pulse) begin
                clr     <= 1'b1;
                cur     <= S_IDLE;
                running <= 1'b0;
            end else begin
                unique case (cur)
                    S_IDLE: begin
                        if (stop_pulse) begin
                            cur     <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (stop_pulse) begin
                            cur     <= S_PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            if (!WRAP && limit_hit) begin
                                cur     <= S_LIMIT;
                                running <= 1'b0;
                            end else begin
                                step <= 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (stop_pulse) begin
                            cur     <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_LIMIT: begin
                        if (stop_pulse) begin
                            cur     <= S_IDLE;
                            running <= 1'b0;
                        end else if (dir_pulse) begin
                            cur     <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        cur     <= S_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - directed self-checking bench for count_sequencer
module tb_count_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic dir_pulse = 1'b0, clear_pulse = 1'b0, stop_pulse = 1'b0;
    logic at_max = 1'b0, at_zero = 1'b0;

    logic       step_w, dir_w, clr_w, running_w;
    logic [1:0] state_w;
    logic       step_s, dir_s, clr_s, running_s;
    logic [1:0] state_s;
    logic       step_i, dir_i, clr_i, running_i;
    logic [1:0] state_i;

    int n_assert = 0;
    int n_fail   = 0;

    // wrapping, auto-start instance
    count_sequencer #(.TICK_DIV(4), .WRAP(1'b1), .AUTO_START(1'b1)) dut_w (
        .CLK(clk), .RST(rst), .dir_pulse(dir_pulse), .clear_pulse(clear_pulse),
        .stop_pulse(stop_pulse), .at_max(at_max), .at_zero(at_zero),
        .step(step_w), .dir(dir_w), .clr(clr_w), .running(running_w), .state(state_w)
    );

    // saturating instance
    count_sequencer #(.TICK_DIV(4), .WRAP(1'b0), .AUTO_START(1'b1)) dut_s (
        .CLK(clk), .RST(rst), .dir_pulse(dir_pulse), .clear_pulse(clear_pulse),
        .stop_pulse(stop_pulse), .at_max(at_max), .at_zero(at_zero),
        .step(step_s), .dir(dir_s), .clr(clr_s), .running(running_s), .state(state_s)
    );

    // idle-at-reset instance
    count_sequencer #(.TICK_DIV(4), .WRAP(1'b1), .AUTO_START(1'b0)) dut_i (
        .CLK(clk), .RST(rst), .dir_pulse(dir_pulse), .clear_pulse(clear_pulse),
        .stop_pulse(stop_pulse), .at_max(at_max), .at_zero(at_zero),
        .step(step_i), .dir(dir_i), .clr(clr_i), .running(running_i), .state(state_i)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_step", step_w, 1'b0);
        chk("rst_clr", clr_w, 1'b0);
        chk("rst_dir", dir_w, 1'b0);
        chk("rst_state", state_w, 2'd1);
        chk("rst_running", running_w, 1'b1);
        chk("rst_state_idle", state_i, 2'd0);
        chk("rst_running_idle", running_i, 1'b0);

        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            chk("free_run_step", step_w, (c % 4) == 0);
        end
        chk("free_run_dir", dir_w, 1'b0);
        chk("free_run_state", state_w, 2'd1);

        // pause two cycles into a period, then resume from the held count
        cyc();
        chk("pre_pause_step", step_w, 1'b0);
        stop_pulse = 1'b1;
        cyc();
        stop_pulse = 1'b0;
        chk("pause_state", state_w, 2'd2);
        chk("pause_running", running_w, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("paused_no_step", step_w, 1'b0);
        end
        stop_pulse = 1'b1;
        cyc();
        stop_pulse = 1'b0;
        chk("resume_state", state_w, 2'd1);
        chk("resume_step0", step_w, 1'b0);
        cyc();
        chk("resume_step1", step_w, 1'b0);
        cyc();
        chk("resume_step2", step_w, 1'b1);

        // stop coincident with tick
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pre_tick_step", step_w, 1'b0);
        end
        stop_pulse = 1'b1;
        cyc();
        stop_pulse = 1'b0;
        chk("stop_tick_step", step_w, 1'b0);
        chk("stop_tick_state", state_w, 2'd2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stop_tick_hold", step_w, 1'b0);
        end
        stop_pulse = 1'b1;
        cyc();
        stop_pulse = 1'b0;
        chk("stop_tick_resume", state_w, 2'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("after_wrap_step", step_w, i == 4);
        end

        // clear together with stop and dir
        clear_pulse = 1'b1;
        stop_pulse  = 1'b1;
        dir_pulse   = 1'b1;
        cyc();
        clear_pulse = 1'b0;
        stop_pulse  = 1'b0;
        dir_pulse   = 1'b0;
        chk("clear_clr", clr_w, 1'b1);
        chk("clear_state", state_w, 2'd0);
        chk("clear_dir", dir_w, 1'b1);
        chk("clear_step", step_w, 1'b0);
        chk("clear_running", running_w, 1'b0);
        cyc();
        chk("clear_clr_one_cycle", clr_w, 1'b0);
        chk("clear_idle_state", state_w, 2'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("idle_no_step", step_w, 1'b0);
        end

        // start from idle, full period before first step
        stop_pulse = 1'b1;
        cyc();
        stop_pulse = 1'b0;
        chk("idle_start_state", state_w, 2'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("idle_start_step", step_w, i == 4);
        end
        chk("idle_start_dir", dir_w, 1'b1);

        // asynchronous reset while paused with dir=1
        stop_pulse = 1'b1;
        cyc();
        stop_pulse = 1'b0;
        chk("pre_rst_state", state_w, 2'd2);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dir", dir_w, 1'b0);
        chk("async_rst_state", state_w, 2'd1);
        chk("async_rst_step", step_w, 1'b0);
        chk("async_rst_running", running_w, 1'b1);
        cyc();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("post_rst_step", step_w, i == 4);
            chk("post_rst_step_sat", step_s, i == 4);
        end

        // saturate at max going up
        at_max = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sat_pre_state", state_s, 2'd1);
        end
        cyc();
        chk("sat_limit_state", state_s, 2'd3);
        chk("sat_limit_step", step_s, 1'b0);
        chk("sat_limit_running", running_s, 1'b0);
        chk("wrap_ignores_max", step_w, 1'b1);
        cyc();
        chk("sat_limit_hold", state_s, 2'd3);
        dir_pulse = 1'b1;
        cyc();
        dir_pulse = 1'b0;
        at_max = 1'b0;
        chk("sat_dir", dir_s, 1'b1);
        chk("sat_rerun_state", state_s, 2'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("sat_rerun_step", step_s, i == 4);
        end

        // saturate at zero going down, then stop leaves limit for idle
        at_zero = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("sat_zero_step", step_s, 1'b0);
        end
        chk("sat_zero_state", state_s, 2'd3);
        at_zero = 1'b0;
        stop_pulse = 1'b1;
        cyc();
        stop_pulse = 1'b0;
        chk("limit_stop_state", state_s, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
